// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - width-configurable left/right/load shift register with frame counter
// Optional rotate input enabled by defining USR_ROTATE_EN.
module universal_shift_register #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      FRAME_LEN   = WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int unsigned     CNT_W       = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
`ifdef USR_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic [CNT_W-1:0] shift_count,
    output logic             frame_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_LEN - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             serial_q, serial_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             frame_q, frame_d;
    logic             is_shift;
    logic             rot_sel;

`ifdef USR_ROTATE_EN
    assign rot_sel = rotate;
`else
    assign rot_sel = 1'b0;
`endif

    always_comb begin
        data_d   = data_q;
        serial_d = serial_q;
        count_d  = count_q;
        frame_d  = 1'b0;
        is_shift = 1'b0;

        case (mode)
            MODE_LEFT: begin
                data_d   = {data_q[WIDTH-2:0], (rot_sel ? data_q[WIDTH-1] : serial_in)};
                serial_d = data_q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_RIGHT: begin
                data_d   = {(rot_sel ? data_q[0] : serial_in), data_q[WIDTH-1:1]};
                serial_d = data_q[0];
                is_shift = 1'b1;
            end
            MODE_LOAD: begin
                // A load abandons any partial frame without signalling it.
                data_d  = parallel_in;
                count_d = '0;
            end
            MODE_HOLD: begin
            end
            default: begin
            end
        endcase

        if (is_shift) begin
            if (count_q == LAST_COUNT) begin
                count_d = '0;
                frame_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= RESET_VALUE;
            serial_q <= 1'b0;
            count_q  <= '0;
            frame_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            serial_q <= serial_d;
            count_q  <= count_d;
            frame_q  <= frame_d;
        end
    end

    assign data_out    = data_q;
    assign serial_out  = serial_q;
    assign shift_count = count_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - vector table plus scoreboard bench for universal_shift_register
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_a, mode_b;
    logic       sin_a, sin_b;
    logic [7:0] pin_a, pin_b;
`ifdef USR_ROTATE_EN
    logic       rot_a;
`endif
    logic [7:0] data_a, data_b;
    logic       ser_a, ser_b;
    logic [3:0] cnt_a;
    logic [1:0] cnt_b;
    logic       fd_a, fd_b;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(8), .FRAME_LEN(8), .RESET_VALUE(8'hA5)) dut_a (
        .clk(clk), .reset(reset), .mode(mode_a), .serial_in(sin_a), .parallel_in(pin_a),
`ifdef USR_ROTATE_EN
        .rotate(rot_a),
`endif
        .data_out(data_a), .serial_out(ser_a), .shift_count(cnt_a), .frame_done(fd_a)
    );

    universal_shift_register #(.WIDTH(8), .FRAME_LEN(3), .RESET_VALUE(8'h00)) dut_b (
        .clk(clk), .reset(reset), .mode(mode_b), .serial_in(sin_b), .parallel_in(pin_b),
`ifdef USR_ROTATE_EN
        .rotate(1'b0),
`endif
        .data_out(data_b), .serial_out(ser_b), .shift_count(cnt_b), .frame_done(fd_b)
    );

    typedef struct {
        int         sel;
        logic [1:0] mode;
        logic       sin;
        logic [7:0] pin;
        logic       rot;
        logic [7:0] data;
        logic       ser;
        int         cnt;
        logic       fd;
    } vec_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       ser;
        int         cnt;
        logic       fd;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(int sel, logic [1:0] m, logic s, logic [7:0] p, logic r,
                                logic [7:0] d, logic so, int c, logic f);
        vecs.push_back('{sel, m, s, p, r, d, so, c, f});
    endfunction

    task automatic check1(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        if (e.sel == 0) begin
            check1({e.tag, " data"}, 64'(data_a), 64'(e.data));
            check1({e.tag, " ser"},  64'(ser_a),  64'(e.ser));
            check1({e.tag, " cnt"},  64'(cnt_a),  64'(e.cnt));
            check1({e.tag, " fd"},   64'(fd_a),   64'(e.fd));
        end else begin
            check1({e.tag, " data"}, 64'(data_b), 64'(e.data));
            check1({e.tag, " ser"},  64'(ser_b),  64'(e.ser));
            check1({e.tag, " cnt"},  64'(cnt_b),  64'(e.cnt));
            check1({e.tag, " fd"},   64'(fd_b),   64'(e.fd));
        end
    endtask

    task automatic step(int sel, logic [1:0] m, logic s, logic [7:0] p, logic r,
                        logic [7:0] d, logic so, int c, logic f, string tag);
        @(negedge clk);
        mode_a = 2'b00;
        mode_b = 2'b00;
        if (sel == 0) begin
            mode_a = m; sin_a = s; pin_a = p;
`ifdef USR_ROTATE_EN
            rot_a = r;
`endif
        end else begin
            mode_b = m; sin_b = s; pin_b = p;
        end
        sb.push_back('{sel, d, so, c, f, tag});
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic check_reset_a(string tag);
        check1({tag, " data"}, 64'(data_a), 64'h A5);
        check1({tag, " ser"},  64'(ser_a),  64'h0);
        check1({tag, " cnt"},  64'(cnt_a),  64'h0);
        check1({tag, " fd"},   64'(fd_a),   64'h0);
    endtask

    logic [7:0] md, nd;
    logic       ms, ns, nf, ins, is_sh, rr;
    int         mc, nc;

    initial begin
        reset  = 1'b1;
        mode_a = 2'b00; sin_a = 1'b0; pin_a = 8'h00;
        mode_b = 2'b00; sin_b = 1'b0; pin_b = 8'h00;
`ifdef USR_ROTATE_EN
        rot_a = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_a("por");
        check1("por_b data", 64'(data_b), 64'h0);
        reset = 1'b0;

        // Reset mid-operation: load, shift three times, then async reset between edges
        step(0, 2'b11, 0, 8'h3C, 0, 8'h3C, 0, 0, 0, "rst_load");
        step(0, 2'b01, 0, 8'h00, 0, 8'h78, 0, 1, 0, "rst_sh1");
        step(0, 2'b01, 0, 8'h00, 0, 8'hF0, 0, 2, 0, "rst_sh2");
        step(0, 2'b01, 0, 8'h00, 0, 8'hE0, 1, 3, 0, "rst_sh3");
        @(negedge clk);
        mode_a = 2'b01;
        #2 reset = 1'b1;
        #1 check_reset_a("async_rst");
        @(posedge clk);
        #1 check_reset_a("rst_held");
        @(negedge clk);
        mode_a = 2'b00;
        reset  = 1'b0;

        // Left-shift deserialise 1,0,1,1,0,0,1,0
        add(0, 2'b11, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h01, 0, 1, 0);
        add(0, 2'b01, 0, 8'h00, 0, 8'h02, 0, 2, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h05, 0, 3, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h0B, 0, 4, 0);
        add(0, 2'b01, 0, 8'h00, 0, 8'h16, 0, 5, 0);
        add(0, 2'b01, 0, 8'h00, 0, 8'h2C, 0, 6, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h59, 0, 7, 0);
        add(0, 2'b01, 0, 8'h00, 0, 8'hB2, 0, 0, 1);
        add(0, 2'b00, 1, 8'h00, 0, 8'hB2, 0, 0, 0);
        // Right-shift serialise 8'h81
        add(0, 2'b11, 0, 8'h81, 0, 8'h81, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h40, 1, 1, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h20, 0, 2, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h10, 0, 3, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h08, 0, 4, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h04, 0, 5, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h02, 0, 6, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h01, 0, 7, 0);
        add(0, 2'b10, 0, 8'h00, 0, 8'h00, 1, 0, 1);
        // Abort and hold
        add(0, 2'b01, 1, 8'h00, 0, 8'h01, 0, 1, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h03, 0, 2, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h07, 0, 3, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h0F, 0, 4, 0);
        add(0, 2'b01, 1, 8'h00, 0, 8'h1F, 0, 5, 0);
        add(0, 2'b00, 1, 8'h00, 0, 8'h1F, 0, 5, 0);
        add(0, 2'b00, 0, 8'h00, 0, 8'h1F, 0, 5, 0);
        add(0, 2'b00, 1, 8'h00, 0, 8'h1F, 0, 5, 0);
        add(0, 2'b11, 0, 8'hFF, 0, 8'hFF, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 0, 8'hFF, 0, 0, 0);
        // FRAME_LEN=3 instance, then a mid-frame direction change
        add(1, 2'b01, 1, 8'h00, 0, 8'h01, 0, 1, 0);
        add(1, 2'b01, 1, 8'h00, 0, 8'h03, 0, 2, 0);
        add(1, 2'b01, 1, 8'h00, 0, 8'h07, 0, 0, 1);
        add(1, 2'b01, 1, 8'h00, 0, 8'h0F, 0, 1, 0);
        add(1, 2'b01, 1, 8'h00, 0, 8'h1F, 0, 2, 0);
        add(1, 2'b01, 1, 8'h00, 0, 8'h3F, 0, 0, 1);
        add(1, 2'b00, 1, 8'h00, 0, 8'h3F, 0, 0, 0);
        add(1, 2'b10, 0, 8'h00, 0, 8'h1F, 1, 1, 0);
        add(1, 2'b01, 0, 8'h00, 0, 8'h3E, 0, 2, 0);
        add(1, 2'b10, 1, 8'h00, 0, 8'h9F, 0, 0, 1);
`ifdef USR_ROTATE_EN
        add(0, 2'b11, 0, 8'h81, 0, 8'h81, 0, 0, 0);
        add(0, 2'b01, 0, 8'h00, 1, 8'h03, 1, 1, 0);
        add(0, 2'b10, 0, 8'h00, 1, 8'h81, 1, 2, 0);
        add(0, 2'b10, 0, 8'h00, 1, 8'hC0, 1, 3, 0);
        add(0, 2'b11, 0, 8'h5A, 1, 8'h5A, 1, 0, 0);
`endif
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].sel, vecs[i].mode, vecs[i].sin, vecs[i].pin, vecs[i].rot,
                 vecs[i].data, vecs[i].ser, vecs[i].cnt, vecs[i].fd, $sformatf("v%0d", i));

        // Random traffic on the FRAME_LEN=8 instance against a behavioural model
        @(negedge clk);
        mode_a = 2'b00;
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        md = 8'hA5; ms = 1'b0; mc = 0;
        for (int i = 0; i < 300; i++) begin
            logic [1:0] m;
            logic       s;
            logic [7:0] p;
            m  = 2'($urandom_range(0, 3));
            s  = 1'($urandom);
            p  = 8'($urandom);
`ifdef USR_ROTATE_EN
            rr = 1'($urandom);
`else
            rr = 1'b0;
`endif
            nd = md; ns = ms; nc = mc; nf = 1'b0; is_sh = 1'b0;
            if (m == 2'b01) begin
                ins = rr ? md[7] : s;
                nd = {md[6:0], ins}; ns = md[7]; is_sh = 1'b1;
            end else if (m == 2'b10) begin
                ins = rr ? md[0] : s;
                nd = {ins, md[7:1]}; ns = md[0]; is_sh = 1'b1;
            end else if (m == 2'b11) begin
                nd = p; nc = 0;
            end
            if (is_sh) begin
                if (mc == 7) begin nc = 0; nf = 1'b1; end
                else nc = mc + 1;
            end
            step(0, m, s, p, rr, nd, ns, nc, nf, $sformatf("rnd%0d", i));
            md = nd; ms = ns; mc = nc;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
